// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU: R-type opcodes, field positions,
// loader state encoding and the legal-opcode check used by encoder and decoder.
package cpu_isa_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 8;
  localparam int RDST_MSB   = 7;
  localparam int RDST_LSB   = 4;
  localparam int RSRC_MSB   = 3;
  localparam int RSRC_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_FULL  = 3'd3,
    ST_DONE  = 3'd4
  } enc_state_t;

  function automatic logic is_legal_rtype(input logic [7:0] opcode);
    case (opcode)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC,
      OP_RSH, OP_SUB, OP_CMP, OP_ALSH, OP_ARSH, OP_LSH: is_legal_rtype = 1'b1;
      default:                                          is_legal_rtype = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_packer.sv
// Combinational R-type packer: {opcode, rdst, rsrc} into a 16-bit word,
// plus a flag telling whether the opcode is a legal R-type instruction.
module instr_packer
  import cpu_isa_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [3:0]  rdst,
  input  logic [3:0]  rsrc,
  output logic [15:0] word,
  output logic        legal
);

  always_comb begin
    word = '0;
    word[OPCODE_MSB:OPCODE_LSB] = opcode;
    word[RDST_MSB:RDST_LSB]     = rdst;
    word[RSRC_MSB:RSRC_LSB]     = rsrc;
  end

  assign legal = is_legal_rtype(opcode);

endmodule

// File: rtl/instr_encoder_loader.sv
// Loads encoded R-type instructions into instruction memory, one word per handshake.
// Optional running XOR checksum of written words: define ENCODER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting instruction fields
// WRITE | one-cycle memory write of the latched word
// FULL  | MEM_DEPTH words written, waiting for finish
// DONE  | program closed, waiting for a new start
module instr_encoder_loader
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_opcode,
  input  logic [3:0]            in_rdst,
  input  logic [3:0]            in_rsrc,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  full,
  output logic                  illegal_op,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [15:0]           checksum
);

  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  enc_state_t            state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [15:0]           pk_word;
  logic                  pk_legal;
  logic                  enter_load;

  instr_packer u_packer (
    .opcode (in_opcode),
    .rdst   (in_rdst),
    .rsrc   (in_rsrc),
    .word   (pk_word),
    .legal  (pk_legal)
  );

  assign enter_load = start && (state == ST_IDLE || state == ST_DONE);
  assign in_ready   = (state == ST_LOAD) && !finish;
  assign busy       = (state == ST_LOAD) || (state == ST_WRITE) || (state == ST_FULL);
  assign done       = (state == ST_DONE);
  assign full       = (state == ST_FULL);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      ptr        <= BASE;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      illegal_op <= 1'b0;
      word_count <= '0;
    end else begin
      mem_we <= 1'b0;
      if (enter_load) begin
        state      <= ST_LOAD;
        ptr        <= BASE;
        mem_addr   <= BASE;
        word_count <= '0;
        illegal_op <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            // finish wins over a simultaneous in_valid
            if (finish) begin
              state <= ST_DONE;
            end else if (in_valid) begin
              if (pk_legal) begin
                mem_we    <= 1'b1;
                mem_addr  <= ptr;
                mem_wdata <= pk_word;
                state     <= ST_WRITE;
              end else begin
                illegal_op <= 1'b1;
              end
            end
          end
          ST_WRITE: begin
            ptr        <= ptr + 1'b1;
            word_count <= word_count + 1'b1;
            state      <= (word_count + 1'b1 == DEPTH) ? ST_FULL : ST_LOAD;
          end
          ST_FULL: if (finish) state <= ST_DONE;
          ST_IDLE, ST_DONE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk) begin
    if (!reset_n)               csum <= '0;
    else if (enter_load)        csum <= '0;
    else if (state == ST_WRITE) csum <= csum ^ mem_wdata;
  end

  assign checksum = csum;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader (MEM_DEPTH=4) against
// a transaction-level model: expected writes are queued at handshake time.
module tb_instr_encoder_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int BASE  = 0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, finish = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_opcode = '0;
  logic [3:0]    in_rdst = '0, in_rsrc = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          busy, done, full, illegal_op;
  logic [AW:0]   word_count;
  logic [15:0]   checksum;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rdst(in_rdst), .in_rsrc(in_rsrc), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .full(full),
    .illegal_op(illegal_op), .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  logic [7:0]  legal_list [13] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84};
  int          m_count;
  bit          m_illegal;
  logic [15:0] m_csum;
  logic [23:0] exp_q [$];

  function automatic bit model_legal(input logic [7:0] op);
    foreach (legal_list[i]) if (legal_list[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_count = 0; m_illegal = 0; m_csum = 16'h0000;
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e[23:16]));
        check("write_data", 32'(mem_wdata), 32'(e[15:0]));
      end
    end
  end

  // all tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(1); start = 1'b0;
    model_clear();
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_addr", 32'(mem_addr), 32'(BASE));
    check("start_count", 32'(word_count), 32'd0);
    check("start_illegal", 32'(illegal_op), 32'd0);
    check("start_csum", 32'(checksum), 32'd0);
  endtask

  task automatic offer(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs);
    bit got = 0;
    bit lg;
    logic [15:0] w;
    lg = model_legal(op);
    w  = {op, rd, rs};
    in_opcode = op; in_rdst = rd; in_rsrc = rs; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in_ready) begin got = 1; break; end
      @(posedge clk); #1;
    end
    if (!got) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      tick(1);
      return;
    end
    tick(1);
    in_valid = 1'b0;
    if (lg) begin
      exp_q.push_back({8'((BASE + m_count) % (1 << AW)), w});
      m_count++;
`ifdef ENCODER_CHECKSUM_EN
      m_csum ^= w;
`endif
      check("we_latency", 32'(mem_we), 32'd1);
      tick(1);
    end else begin
      m_illegal = 1;
      check("illegal_no_we", 32'(mem_we), 32'd0);
      check("illegal_flag", 32'(illegal_op), 32'd1);
    end
  endtask

  task automatic try_full();
    in_opcode = 8'h05; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_not_ready", 32'(in_ready), 32'd0);
      check("full_flag", 32'(full), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_finish();
    finish = 1'b1; tick(1); finish = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_count", 32'(word_count), 32'(m_count));
    check("fin_illegal", 32'(illegal_op), 32'(m_illegal));
    check("fin_csum", 32'(checksum), 32'(m_csum));
    check("fin_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    model_clear();
    tick(2);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(BASE));
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_csum", 32'(checksum), 32'd0);
    reset_n = 1'b1;
    in_valid = 1'b1; in_opcode = 8'h05;
    tick(2);
    in_valid = 1'b0;
    check("idle_ignores_valid", 32'(busy), 32'd0);

    // directed program: add, lsh, illegal, and, fill to FULL
    do_start();
    offer(8'h05, 4'd3, 4'd5);
    offer(8'h84, 4'd1, 4'd2);
    check("two_words_count", 32'(word_count), 32'd2);
`ifdef ENCODER_CHECKSUM_EN
    check("csum_pair", 32'(checksum), 32'h8127);
`else
    check("csum_tied", 32'(checksum), 32'h0);
`endif
    offer(8'h0A, 4'd1, 4'd1);
    tick(2);
    check("illegal_sticky", 32'(illegal_op), 32'd1);
    check("addr_held", 32'(mem_addr), 32'd1);
    offer(8'h01, 4'd7, 4'd8);
    offer(8'h0F, 4'd9, 4'd10);
    tick(1);
    check("full_after_depth", 32'(full), 32'd1);
    try_full();
    do_finish();

    // finish and in_valid together: finish wins
    do_start();
    offer(8'h02, 4'd4, 4'd4);
    offer(8'h03, 4'd5, 4'd6);
    finish = 1'b1; in_valid = 1'b1; in_opcode = 8'h09;
    #1;
    check("finish_blocks_ready", 32'(in_ready), 32'd0);
    tick(1);
    finish = 1'b0; in_valid = 1'b0;
    check("finish_done", 32'(done), 32'd1);
    check("finish_no_we", 32'(mem_we), 32'd0);
    tick(1);
    check("finish_queue_empty", 32'(exp_q.size()), 32'd0);
    do_start();

    // reset during WRITE
    in_opcode = 8'h06; in_rdst = 4'd2; in_rsrc = 4'd3; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
    exp_q.push_back({8'(BASE), 16'h0623});
    check("rw_we_before", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    tick(1);
    check("rw_we_after", 32'(mem_we), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_count", 32'(word_count), 32'd0);
    reset_n = 1'b1;
    model_clear();
    tick(3);
    check("rw_idle", 32'(busy), 32'd0);
    check("rw_queue_empty", 32'(exp_q.size()), 32'd0);

    // randomized programs
    for (int p = 0; p < 30; p++) begin
      int n;
      do_start();
      n = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) begin
        logic [7:0] op;
        if ($urandom_range(0, 3) != 0) op = legal_list[$urandom_range(0, 12)];
        else op = 8'($urandom);
        if (m_count == DEPTH) try_full();
        else offer(op, 4'($urandom), 4'($urandom));
        tick($urandom_range(0, 2));
      end
      do_finish();
      tick($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
